sha1_arbiter: RTL



---
 rtl/sha1_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/sha1_arbiter.sv
// sha1_arbiter: shares one SHA1 engine between two requesters.
// Round-robin grant without preemption; each job goes through engine reset
// (LOAD), run (RUN) and result capture (DONE), with a watchdog that aborts
// a run that never reports completion (ABORT).
//
// Ports:
//   wb_clk_i, reset_n          clock, async active-low reset
//   req0_i/req1_i, msg0_i/1_i  request levels and 512-bit message blocks
//   ack0_o/ack1_o              pulse: message latched, job started
//   done0_o/done1_o            pulse: digest_o valid for that owner
//   err0_o/err1_o              pulse: job aborted by the watchdog
//   digest_o                   last successfully captured digest
//   busy_o, owner_o            job in flight / requester currently or last served
//   eng_rst_o, eng_on_o        engine reset and run enable
//   eng_msg_o                  latched message driven to the engine
//   eng_digest_i, eng_finish_i engine result and completion flag
module sha1_arbiter #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic         wb_clk_i,
    input  logic         reset_n,
    input  logic         req0_i,
    input  logic         req1_i,
    input  logic [511:0] msg0_i,
    input  logic [511:0] msg1_i,
    output logic         ack0_o,
    output logic         ack1_o,
    output logic         done0_o,
    output logic         done1_o,
    output logic         err0_o,
    output logic         err1_o,
    output logic [159:0] digest_o,
    output logic         busy_o,
    output logic         owner_o,
    output logic         eng_rst_o,
    output logic         eng_on_o,
    output logic [511:0] eng_msg_o,
    input  logic [159:0] eng_digest_i,
    input  logic         eng_finish_i
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE,
        S_ABORT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wdog_cnt;
    logic             grant_c;

    // Winner selection: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        grant_c = req1_i;
        if (req0_i && req1_i) begin
            grant_c = ~owner_o;
        end
    end

    // Job sequencer with registered outputs; pulses default low every cycle.
    always_ff @(posedge wb_clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            wdog_cnt  <= '0;
            ack0_o    <= 1'b0;
            ack1_o    <= 1'b0;
            done0_o   <= 1'b0;
            done1_o   <= 1'b0;
            err0_o    <= 1'b0;
            err1_o    <= 1'b0;
            digest_o  <= '0;
            busy_o    <= 1'b0;
            owner_o   <= 1'b1;
            eng_rst_o <= 1'b1;
            eng_on_o  <= 1'b0;
            eng_msg_o <= '0;
        end else begin
            ack0_o  <= 1'b0;
            ack1_o  <= 1'b0;
            done0_o <= 1'b0;
            done1_o <= 1'b0;
            err0_o  <= 1'b0;
            err1_o  <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (req0_i || req1_i) begin
                        owner_o   <= grant_c;
                        eng_msg_o <= grant_c ? msg1_i : msg0_i;
                        ack0_o    <= ~grant_c;
                        ack1_o    <= grant_c;
                        eng_rst_o <= 1'b1;
                        busy_o    <= 1'b1;
                        state     <= S_LOAD;
                    end else begin
                        eng_rst_o <= 1'b0;
                    end
                end

                S_LOAD: begin
                    eng_rst_o <= 1'b0;
                    eng_on_o  <= 1'b1;
                    wdog_cnt  <= '0;
                    state     <= S_RUN;
                end

                // Completion takes priority over a watchdog expiry in the same cycle.
                S_RUN: begin
                    wdog_cnt <= wdog_cnt + CNT_W'(1);
                    if (eng_finish_i) begin
                        digest_o <= eng_digest_i;
                        eng_on_o <= 1'b0;
                        done0_o  <= ~owner_o;
                        done1_o  <= owner_o;
                        state    <= S_DONE;
                    end else if (wdog_cnt == CNT_LAST) begin
                        eng_on_o  <= 1'b0;
                        eng_rst_o <= 1'b1;
                        err0_o    <= ~owner_o;
                        err1_o    <= owner_o;
                        state     <= S_ABORT;
                    end
                end

                S_DONE, S_ABORT: begin
                    eng_rst_o <= 1'b0;
                    busy_o    <= 1'b0;
                    state     <= S_IDLE;
                end

                default: begin
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule
